// File: rtl/sw_job_scheduler.sv
// sw_job_scheduler: spreads Smith-Waterman alignment jobs over NUM_ACC accelerator slots
// and returns tagged results through a single round-robin arbitrated valid/ready stream.
module sw_job_scheduler #(
    parameter int L       = 8,
    parameter int NUM_ACC = 2,
    parameter int TAG_W   = 4,
    parameter int TIMEOUT = 255,
    parameter int MASK    = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         job_valid,
    output logic                         job_ready,
    input  logic [3*L-1:0]               job_r,
    input  logic [3*L-1:0]               job_q,
    input  logic [TAG_W-1:0]             job_tag,
    output logic [NUM_ACC-1:0]           acc_start,
    output logic [NUM_ACC*3*L-1:0]       acc_r,
    output logic [NUM_ACC*3*L-1:0]       acc_q,
    input  logic [NUM_ACC-1:0]           acc_done,
    input  logic [NUM_ACC*(3*L+6)-1:0]   acc_r_aln,
    input  logic [NUM_ACC*(3*L+6)-1:0]   acc_q_aln,
    output logic                         res_valid,
    input  logic                         res_ready,
    output logic [3*L+5:0]               res_r,
    output logic [3*L+5:0]               res_q,
    output logic [TAG_W-1:0]             res_tag,
    output logic                         res_timeout,
    output logic [NUM_ACC-1:0]           busy
);
    localparam int SW = 3 * L;
    localparam int AW = 3 * L + 6;
    localparam int PW = (NUM_ACC > 1) ? $clog2(NUM_ACC) : 1;
    localparam logic [7:0] MASK_C    = 8'(MASK);
    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

    typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_RUN, S_HOLD} slot_state_e;

    slot_state_e      state_q [NUM_ACC];
    slot_state_e      state_d [NUM_ACC];
    logic [SW-1:0]    r_q     [NUM_ACC];
    logic [SW-1:0]    r_d     [NUM_ACC];
    logic [SW-1:0]    q_q     [NUM_ACC];
    logic [SW-1:0]    q_d     [NUM_ACC];
    logic [TAG_W-1:0] tag_q   [NUM_ACC];
    logic [TAG_W-1:0] tag_d   [NUM_ACC];
    logic [7:0]       cnt_q   [NUM_ACC];
    logic [7:0]       cnt_d   [NUM_ACC];
    logic [AW-1:0]    aln_r_q [NUM_ACC];
    logic [AW-1:0]    aln_r_d [NUM_ACC];
    logic [AW-1:0]    aln_q_q [NUM_ACC];
    logic [AW-1:0]    aln_q_d [NUM_ACC];
    logic             to_q    [NUM_ACC];
    logic             to_d    [NUM_ACC];

    logic [PW-1:0]    ptr_q, ptr_d;
    logic             res_valid_q, res_valid_d;
    logic [AW-1:0]    res_r_q, res_r_d;
    logic [AW-1:0]    res_q_q, res_q_d;
    logic [TAG_W-1:0] res_tag_q, res_tag_d;
    logic             res_timeout_q, res_timeout_d;

    logic             free_found, hold_found, accept, load;
    logic [PW-1:0]    free_idx, gnt_idx;

    // Slot selection: lowest IDLE slot takes a new job; HOLD slots compete for the output.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        hold_found = 1'b0;
        gnt_idx    = '0;
        for (int i = NUM_ACC - 1; i >= 0; i--) begin
            if (state_q[i] == S_IDLE) begin
                free_found = 1'b1;
                free_idx   = PW'(i);
            end
            if (state_q[i] == S_HOLD) begin
                hold_found = 1'b1;
                gnt_idx    = PW'(i);
            end
        end
        // Wrap-around search: a HOLD slot at or above the pointer beats any below it.
        for (int i = NUM_ACC - 1; i >= 0; i--) begin
            if (state_q[i] == S_HOLD && PW'(i) >= ptr_q) gnt_idx = PW'(i);
        end
        accept = job_valid && free_found;
        load   = hold_found && (!res_valid_q || res_ready);
    end

    always_comb begin
        // NOTE: every _d starts from its held value so no path through this block infers a latch.
        ptr_d         = ptr_q;
        res_valid_d   = res_valid_q;
        res_r_d       = res_r_q;
        res_q_d       = res_q_q;
        res_tag_d     = res_tag_q;
        res_timeout_d = res_timeout_q;
        for (int i = 0; i < NUM_ACC; i++) begin
            state_d[i] = state_q[i];
            r_d[i]     = r_q[i];
            q_d[i]     = q_q[i];
            tag_d[i]   = tag_q[i];
            cnt_d[i]   = cnt_q[i];
            aln_r_d[i] = aln_r_q[i];
            aln_q_d[i] = aln_q_q[i];
            to_d[i]    = to_q[i];
            case (state_q[i])
                S_IDLE: begin
                    if (accept && free_idx == PW'(i)) begin
                        state_d[i] = S_LAUNCH;
                        r_d[i]     = job_r;
                        q_d[i]     = job_q;
                        tag_d[i]   = job_tag;
                    end
                end
                S_LAUNCH: begin
                    state_d[i] = S_RUN;
                    cnt_d[i]   = '0;
                end
                S_RUN: begin
                    cnt_d[i] = cnt_q[i] + 8'd1;
                    // Early done is stale ready from the previous job; done beats timeout.
                    if (cnt_q[i] >= MASK_C && acc_done[i]) begin
                        state_d[i] = S_HOLD;
                        aln_r_d[i] = acc_r_aln[i*AW +: AW];
                        aln_q_d[i] = acc_q_aln[i*AW +: AW];
                        to_d[i]    = 1'b0;
                    end else if (cnt_q[i] == TIMEOUT_C) begin
                        state_d[i] = S_HOLD;
                        aln_r_d[i] = '0;
                        aln_q_d[i] = '0;
                        to_d[i]    = 1'b1;
                    end
                end
                S_HOLD: begin
                    if (load && gnt_idx == PW'(i)) state_d[i] = S_IDLE;
                end
                default: state_d[i] = S_IDLE;
            endcase
        end
        if (load) begin
            res_valid_d   = 1'b1;
            res_r_d       = aln_r_q[gnt_idx];
            res_q_d       = aln_q_q[gnt_idx];
            res_tag_d     = tag_q[gnt_idx];
            res_timeout_d = to_q[gnt_idx];
            ptr_d         = (gnt_idx == PW'(NUM_ACC - 1)) ? '0 : gnt_idx + PW'(1);
        end else if (res_ready) begin
            res_valid_d = 1'b0;
        end
    end

    // NOTE: sequential state is written with non-blocking assignments only, here and nowhere else.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: the per-slot payload arrays are reset too, so acc_r/acc_q read zero after reset.
            for (int i = 0; i < NUM_ACC; i++) begin
                state_q[i] <= S_IDLE;
                r_q[i]     <= '0;
                q_q[i]     <= '0;
                tag_q[i]   <= '0;
                cnt_q[i]   <= '0;
                aln_r_q[i] <= '0;
                aln_q_q[i] <= '0;
                to_q[i]    <= 1'b0;
            end
            ptr_q         <= '0;
            res_valid_q   <= 1'b0;
            res_r_q       <= '0;
            res_q_q       <= '0;
            res_tag_q     <= '0;
            res_timeout_q <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_ACC; i++) begin
                state_q[i] <= state_d[i];
                r_q[i]     <= r_d[i];
                q_q[i]     <= q_d[i];
                tag_q[i]   <= tag_d[i];
                cnt_q[i]   <= cnt_d[i];
                aln_r_q[i] <= aln_r_d[i];
                aln_q_q[i] <= aln_q_d[i];
                to_q[i]    <= to_d[i];
            end
            ptr_q         <= ptr_d;
            res_valid_q   <= res_valid_d;
            res_r_q       <= res_r_d;
            res_q_q       <= res_q_d;
            res_tag_q     <= res_tag_d;
            res_timeout_q <= res_timeout_d;
        end
    end

    always_comb begin
        job_ready = free_found;
        acc_start = '0;
        busy      = '0;
        acc_r     = '0;
        acc_q     = '0;
        for (int i = 0; i < NUM_ACC; i++) begin
            acc_start[i]        = (state_q[i] == S_LAUNCH);
            busy[i]             = (state_q[i] != S_IDLE);
            acc_r[i*SW +: SW]   = r_q[i];
            acc_q[i*SW +: SW]   = q_q[i];
        end
        res_valid   = res_valid_q;
        res_r       = res_r_q;
        res_q       = res_q_q;
        res_tag     = res_tag_q;
        res_timeout = res_timeout_q;
    end

endmodule

// File: tb/tb_sw_job_scheduler.sv
// tb_sw_job_scheduler: directed self-checking bench for sw_job_scheduler (NUM_ACC=2, L=8).
module tb_sw_job_scheduler;
    localparam int L       = 8;
    localparam int NUM_ACC = 2;
    localparam int TAG_W   = 4;
    localparam int SW      = 3 * L;
    localparam int AW      = 3 * L + 6;

    logic                     clk = 1'b0;
    logic                     reset = 1'b1;
    logic                     job_valid = 1'b0;
    logic                     job_ready;
    logic [SW-1:0]            job_r = '0;
    logic [SW-1:0]            job_q = '0;
    logic [TAG_W-1:0]         job_tag = '0;
    logic [NUM_ACC-1:0]       acc_start;
    logic [NUM_ACC*SW-1:0]    acc_r;
    logic [NUM_ACC*SW-1:0]    acc_q;
    logic [NUM_ACC-1:0]       acc_done = '0;
    logic [NUM_ACC*AW-1:0]    acc_r_aln = '0;
    logic [NUM_ACC*AW-1:0]    acc_q_aln = '0;
    logic                     res_valid;
    logic                     res_ready = 1'b0;
    logic [AW-1:0]            res_r;
    logic [AW-1:0]            res_q;
    logic [TAG_W-1:0]         res_tag;
    logic                     res_timeout;
    logic [NUM_ACC-1:0]       busy;

    localparam logic [AW-1:0] R0 = 30'h1234_5678;
    localparam logic [AW-1:0] Q0 = 30'h0765_4321;
    localparam logic [AW-1:0] R1 = 30'h2AAA_5555;
    localparam logic [AW-1:0] Q1 = 30'h1555_2AAA;

    always #5 clk = ~clk;

    sw_job_scheduler #(
        .L(L), .NUM_ACC(NUM_ACC), .TAG_W(TAG_W), .TIMEOUT(255), .MASK(2)
    ) dut (
        .clk(clk), .reset(reset),
        .job_valid(job_valid), .job_ready(job_ready),
        .job_r(job_r), .job_q(job_q), .job_tag(job_tag),
        .acc_start(acc_start), .acc_r(acc_r), .acc_q(acc_q),
        .acc_done(acc_done), .acc_r_aln(acc_r_aln), .acc_q_aln(acc_q_aln),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_r(res_r), .res_q(res_q), .res_tag(res_tag), .res_timeout(res_timeout),
        .busy(busy)
    );

    int n_checks = 0;
    int n_errors = 0;
    int n;
    int tag_cnt [16];
    logic ready_seen;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset     = 1'b1;
        job_valid = 1'b0;
        res_ready = 1'b0;
        acc_done  = '0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic send_job(input logic [SW-1:0] r, input logic [SW-1:0] q, input logic [TAG_W-1:0] tag);
        int w = 0;
        job_valid = 1'b1;
        job_r     = r;
        job_q     = q;
        job_tag   = tag;
        while (!job_ready && w < 50) begin
            tick();
            w++;
        end
        check("job_accept_wait", 128'(job_ready), 128'(1));
        tick();
        job_valid = 1'b0;
    endtask

    task automatic wait_res(input int limit, output int cnt);
        cnt = 0;
        while (!res_valid && cnt < limit) begin
            tick();
            cnt++;
        end
    endtask

    task automatic consume();
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach its summary");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 16; i++) tag_cnt[i] = 0;
        acc_r_aln = {R1, R0};
        acc_q_aln = {Q1, Q0};

        // Reset state and a single job with a 40-cycle accelerator.
        apply_reset();
        check("rst_job_ready", 128'(job_ready), 128'(1));
        check("rst_ctrl", 128'({res_valid, res_timeout, res_tag, acc_start, busy}), 128'(0));
        check("rst_res_rq", 128'({res_r, res_q}), 128'(0));
        check("rst_acc_rq", 128'({acc_r, acc_q}), 128'(0));
        send_job(24'h123456, 24'h654321, 4'd3);
        check("t1_start", 128'(acc_start), 128'(2'b01));
        check("t1_acc_rq", 128'({acc_r[SW-1:0], acc_q[SW-1:0]}), 128'({24'h123456, 24'h654321}));
        tick();
        check("t1_start_pulse", 128'(acc_start), 128'(0));
        repeat (39) tick();
        check("t1_run_quiet", 128'({res_valid, busy, acc_r[SW-1:0]}), 128'({1'b0, 2'b01, 24'h123456}));
        acc_done = 2'b01;
        tick();
        check("t1_hold", 128'({res_valid, busy}), 128'(3'b001));
        tick();
        check("t1_res", 128'({res_valid, res_timeout, res_tag}), 128'({1'b1, 1'b0, 4'd3}));
        check("t1_res_rq", 128'({res_r, res_q}), 128'({R0, Q0}));
        check("t1_busy_free", 128'(busy), 128'(0));
        acc_done = '0;
        consume();
        check("t1_res_drop", 128'(res_valid), 128'(0));

        // Four jobs on two slots: the third waits for the first grant.
        apply_reset();
        send_job(24'h000004, 24'h000040, 4'd4);
        send_job(24'h000005, 24'h000050, 4'd5);
        check("t2_full", 128'({job_ready, busy}), 128'(3'b011));
        job_valid  = 1'b1;
        job_r      = 24'h000006;
        job_q      = 24'h000060;
        job_tag    = 4'd6;
        acc_done   = 2'b01;
        ready_seen = 1'b0;
        n = 0;
        while (!res_valid && n < 20) begin
            ready_seen |= job_ready;
            tick();
            n++;
        end
        check("t2_ready_low", 128'(ready_seen), 128'(0));
        check("t2_res_lat", 128'(n), 128'(4));
        check("t2_first", 128'({res_tag, job_ready, busy}), 128'({4'd4, 1'b1, 2'b10}));
        tag_cnt[res_tag]++;
        acc_done = '0;
        tick();
        job_valid = 1'b0;
        check("t2_third_start", 128'(acc_start), 128'(2'b01));
        check("t2_res_stall", 128'({res_valid, res_tag}), 128'({1'b1, 4'd4}));
        consume();
        acc_done = 2'b10;
        wait_res(20, n);
        check("t2_second", 128'({res_valid, res_tag}), 128'({1'b1, 4'd5}));
        tag_cnt[res_tag]++;
        consume();
        acc_done = '0;
        send_job(24'h000007, 24'h000070, 4'd7);
        check("t2_fourth_start", 128'(acc_start), 128'(2'b10));
        acc_done = 2'b11;
        for (int k = 0; k < 2; k++) begin
            wait_res(20, n);
            check("t2_tail_valid", 128'(res_valid), 128'(1));
            tag_cnt[res_tag]++;
            consume();
        end
        acc_done = '0;
        for (int t = 4; t < 8; t++) check($sformatf("t2_tag%0d_once", t), 128'(tag_cnt[t]), 128'(1));
        check("t2_all_idle", 128'(busy), 128'(0));

        // Simultaneous finish and round-robin rotation.
        apply_reset();
        send_job(24'h000011, 24'h000111, 4'd1);
        send_job(24'h000022, 24'h000222, 4'd2);
        repeat (4) tick();
        acc_done  = 2'b11;
        res_ready = 1'b1;
        wait_res(20, n);
        check("t3_tie_lat", 128'(n), 128'(2));
        check("t3_tie_first", 128'({res_tag, res_r, res_q}), 128'({4'd1, R0, Q0}));
        tick();
        check("t3_tie_second", 128'({res_valid, res_tag, res_r, res_q}), 128'({1'b1, 4'd2, R1, Q1}));
        tick();
        check("t3_tie_drain", 128'(res_valid), 128'(0));
        res_ready = 1'b0;
        acc_done  = '0;
        send_job(24'h000033, 24'h000333, 4'd3);
        acc_done = 2'b01;
        wait_res(20, n);
        check("t3_solo", 128'({res_valid, res_tag}), 128'({1'b1, 4'd3}));
        consume();
        acc_done = '0;
        send_job(24'h000044, 24'h000444, 4'd4);
        send_job(24'h000055, 24'h000555, 4'd5);
        repeat (4) tick();
        acc_done = 2'b11;
        wait_res(20, n);
        check("t3_rot_first", 128'({res_valid, res_tag}), 128'({1'b1, 4'd5}));
        consume();
        check("t3_rot_second", 128'({res_valid, res_tag}), 128'({1'b1, 4'd4}));
        consume();
        check("t3_rot_drain", 128'(res_valid), 128'(0));
        acc_done = '0;

        // Back-pressure: output and the second HOLD slot keep their captured values.
        apply_reset();
        acc_r_aln = {R1, R0};
        acc_q_aln = {Q1, Q0};
        send_job(24'h000088, 24'h000888, 4'd8);
        send_job(24'h000099, 24'h000999, 4'd9);
        repeat (4) tick();
        acc_done = 2'b11;
        wait_res(20, n);
        check("t4_first", 128'({res_valid, res_tag, res_r, res_q}), 128'({1'b1, 4'd8, R0, Q0}));
        acc_r_aln = '1;
        acc_q_aln = '1;
        for (int k = 0; k < 10; k++) begin
            tick();
            check("t4_stall", 128'({res_valid, res_tag, res_r, res_q, busy}),
                  128'({1'b1, 4'd8, R0, Q0, 2'b10}));
        end
        res_ready = 1'b1;
        tick();
        check("t4_second", 128'({res_valid, res_tag, res_r, res_q, busy}),
              128'({1'b1, 4'd9, R1, Q1, 2'b00}));
        tick();
        check("t4_drain", 128'(res_valid), 128'(0));
        res_ready = 1'b0;
        acc_done  = '0;

        // Timeout, slot reuse, stale done masked after start.
        apply_reset();
        acc_r_aln = {R1, R0};
        acc_q_aln = {Q1, Q0};
        send_job(24'h0000AA, 24'h000AAA, 4'd10);
        wait_res(400, n);
        check("t5_timeout_lat", 128'(n), 128'(258));
        check("t5_timeout_res", 128'({res_valid, res_timeout, res_tag}), 128'({1'b1, 1'b1, 4'd10}));
        check("t5_timeout_zero", 128'({res_r, res_q}), 128'(0));
        consume();
        send_job(24'h0000BB, 24'h000BBB, 4'd11);
        acc_done = 2'b01;
        wait_res(20, n);
        check("t5_reuse_lat", 128'(n), 128'(5));
        check("t5_reuse_res", 128'({res_timeout, res_tag, res_r, res_q}), 128'({1'b0, 4'd11, R0, Q0}));
        consume();
        send_job(24'h0000CC, 24'h000CCC, 4'd12);
        wait_res(20, n);
        check("t6_mask_lat", 128'(n), 128'(5));
        check("t6_mask_res", 128'({res_valid, res_tag}), 128'({1'b1, 4'd12}));
        consume();

        // Reset mid-RUN with a result pending.
        acc_done = '0;
        send_job(24'h0000DD, 24'h000DDD, 4'd13);
        send_job(24'h0000EE, 24'h000EEE, 4'd14);
        acc_done = 2'b10;
        wait_res(20, n);
        check("t6_pending", 128'({res_valid, res_tag, busy}), 128'({1'b1, 4'd14, 2'b01}));
        #3;
        reset = 1'b1;
        #1;
        check("t6_rst_ctrl", 128'({res_valid, res_timeout, res_tag, acc_start, busy}), 128'(0));
        check("t6_rst_data", 128'({res_r, res_q}), 128'(0));
        check("t6_rst_acc", 128'({acc_r, acc_q}), 128'(0));
        acc_done = '0;
        tick();
        reset = 1'b0;
        tick();
        check("t6_after_rst", 128'({job_ready, res_valid, busy}), 128'({1'b1, 1'b0, 2'b00}));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
